// File: rtl/multi_timer_pkg.sv
// Shared configuration package for the memory-mapped multi-channel timer.
// Holds the base address, register offsets and the per-channel control
// register layout. Everything that needs the timer map imports this package.
package configurations;

  // Byte address of the first timer register on the data-memory bus.
  localparam logic [63:0] MTIMER_BASE_ADDR = 64'h0000_0000_4000_0000;

  // Offsets from MTIMER_BASE_ADDR. Every register is 8 bytes wide.
  localparam int MTIMER_CNT_OFF     = 'h00;
  localparam int MTIMER_STATUS_OFF  = 'h08;
  localparam int MTIMER_CH_BASE_OFF = 'h20;
  localparam int MTIMER_CH_STRIDE   = 'h20;

  // Width of the implemented part of CTRL_i.
  localparam int MTIMER_CTRL_BITS = 3;

  // Per-channel control register. Declared MSB first, so en lands on bit 0,
  // periodic on bit 1 and ie on bit 2 of the bus view.
  typedef struct packed {
    logic ie;
    logic periodic;
    logic en;
  } mtimer_ctrl_t;

endpackage

// File: rtl/multi_timer_channel.sv
// One compare channel of the multi-channel timer: CMP, PERIOD and CTRL
// registers, the match comparator, the periodic reload adder and the
// pending flag.
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   counter        - registered value of the shared free-running counter
//   write_data     - bus write data
//   cmp_write      - CPU store to CMP of this channel this cycle
//   period_write   - CPU store to PERIOD of this channel this cycle
//   ctrl_write     - CPU store to CTRL of this channel this cycle
//   status_clear   - write-1-to-clear hit on this channel's STATUS bit
//   cmp, period    - current register values (for bus reads)
//   ctrl           - current control bits
//   pending        - raw pending flag
module timer_channel
  import configurations::*;
#(
  parameter int width = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [width-1:0] counter,
  input  logic [width-1:0] write_data,
  input  logic         cmp_write,
  input  logic         period_write,
  input  logic         ctrl_write,
  input  logic         status_clear,
  output logic [width-1:0] cmp,
  output logic [width-1:0] period,
  output mtimer_ctrl_t ctrl,
  output logic         pending
);

  logic [width-1:0] cmp_next;
  logic [width-1:0] period_next;
  logic [MTIMER_CTRL_BITS-1:0] ctrl_bits;
  mtimer_ctrl_t     ctrl_next;
  logic             pending_next;
  logic             match;

  assign ctrl = mtimer_ctrl_t'(ctrl_bits);

  // Match uses only registered values, so a CPU write landing in the same
  // cycle cannot affect whether this cycle matches.
  assign match = ctrl.en && (counter == cmp);

  // Next-state for the channel registers. CPU writes take priority over the
  // hardware updates (periodic reload, one-shot disable); a new match takes
  // priority over a write-1-to-clear so no event is ever lost.
  always_comb begin
    cmp_next     = cmp;
    period_next  = period;
    ctrl_next    = ctrl;
    pending_next = pending;

    if (match && ctrl.periodic) cmp_next = cmp + period;
    if (cmp_write)              cmp_next = write_data;

    if (period_write) period_next = write_data;

    if (match && !ctrl.periodic) ctrl_next.en = 1'b0;
    if (ctrl_write) ctrl_next = mtimer_ctrl_t'(write_data[MTIMER_CTRL_BITS-1:0]);

    if (status_clear) pending_next = 1'b0;
    if (match)        pending_next = 1'b1;
  end

  register #(.width(width), .reset_value({width{1'b1}})) cmp_reg (
    .clock(clock), .reset(reset), .d(cmp_next), .q(cmp)
  );

  register #(.width(width), .reset_value('0)) period_reg (
    .clock(clock), .reset(reset), .d(period_next), .q(period)
  );

  register #(.width(MTIMER_CTRL_BITS), .reset_value('0)) ctrl_reg (
    .clock(clock), .reset(reset), .d(ctrl_next), .q(ctrl_bits)
  );

  register #(.width(1), .reset_value(1'b0)) pending_reg (
    .clock(clock), .reset(reset), .d(pending_next), .q(pending)
  );

endmodule

// File: rtl/register.sv
// Generic storage primitive used for every flop in the timer.
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-high; q returns to reset_value at once
//   d      - next value, captured on every rising clock edge
//   q      - stored value
module register #(
  parameter int               width       = 1,
  parameter logic [width-1:0] reset_value = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  // Plain D flop with asynchronous reset; any hold/enable behaviour is
  // folded into d by the caller.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= reset_value;
    else       q <= d;
  end

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped multi-channel timer on the data-memory bus. One free-running
// counter feeds `channels` compare channels; the OR of enabled pending
// channels drives the core's timer interrupt.
// Ports:
//   clock, reset    - system clock, asynchronous active-high reset
//   address, data   - bus byte address and write data
//   MemRead         - load strobe
//   MemWrite        - store strobe
//   rdata           - read data, released (high-Z) unless a load hits here
//   TimerAddress    - address decodes to a register of this block
//   TimerInterrupt  - OR over channels of pending & IE
//   irq_pending     - raw pending bits
module multi_timer
  import configurations::*;
#(
  parameter int width    = 64,
  parameter int channels = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [width-1:0]    address,
  input  logic [width-1:0]    data,
  input  logic                MemRead,
  input  logic                MemWrite,
  output logic [width-1:0]    rdata,
  output logic                TimerAddress,
  output logic                TimerInterrupt,
  output logic [channels-1:0] irq_pending
);

  localparam logic [width-1:0] BASE = width'(MTIMER_BASE_ADDR);
  localparam int STRIDE_SHIFT = $clog2(MTIMER_CH_STRIDE);

  logic [width-1:0] counter_q;
  logic [width-1:0] counter_d;

  logic [width-1:0] offset;
  logic [width-1:0] ch_offset;
  logic [width-1:0] ch_idx;
  logic [STRIDE_SHIFT-4:0] ch_reg;
  logic is_cnt;
  logic is_status;
  logic is_channel;
  logic write_hit;
  logic [width-1:0] read_value;

  logic [channels-1:0] cmp_we;
  logic [channels-1:0] period_we;
  logic [channels-1:0] ctrl_we;
  logic [channels-1:0] status_clear;
  logic [channels-1:0] pending;
  logic [channels-1:0] ie_vec;

  logic [width-1:0] cmp_q    [channels];
  logic [width-1:0] period_q [channels];
  mtimer_ctrl_t     ctrl_q   [channels];

  // Address decode. The channel window is split into a channel index and a
  // register slot; slot 3 of each channel is reserved but still claims the
  // address. An address below the base wraps to a huge offset and so falls
  // outside every window.
  always_comb begin
    offset     = address - BASE;
    ch_offset  = offset - width'(MTIMER_CH_BASE_OFF);
    ch_idx     = ch_offset >> STRIDE_SHIFT;
    ch_reg     = ch_offset[STRIDE_SHIFT-1:3];
    is_cnt     = (offset == width'(MTIMER_CNT_OFF));
    is_status  = (offset == width'(MTIMER_STATUS_OFF));
    is_channel = (offset >= width'(MTIMER_CH_BASE_OFF)) &&
                 (ch_idx < width'(channels)) &&
                 (offset[2:0] == 3'b000);
  end

  assign TimerAddress = is_cnt || is_status || is_channel;
  assign write_hit    = MemWrite && TimerAddress;

  // Per-channel write strobes and STATUS write-1-to-clear mask.
  always_comb begin
    cmp_we       = '0;
    period_we    = '0;
    ctrl_we      = '0;
    status_clear = '0;
    for (int i = 0; i < channels; i++) begin
      if (write_hit && is_channel && ch_idx == width'(i)) begin
        cmp_we[i]    = (int'(ch_reg) == 0);
        period_we[i] = (int'(ch_reg) == 1);
        ctrl_we[i]   = (int'(ch_reg) == 2);
      end
      status_clear[i] = write_hit && is_status && data[i];
    end
  end

  // Counter: a CNT store replaces the increment for that cycle.
  always_comb begin
    counter_d = counter_q + width'(1);
    if (write_hit && is_cnt) counter_d = data;
  end

  register #(.width(width), .reset_value('0)) counter_reg (
    .clock(clock), .reset(reset), .d(counter_d), .q(counter_q)
  );

  for (genvar g = 0; g < channels; g++) begin : gen_channel
    timer_channel #(.width(width)) u_channel (
      .clock        (clock),
      .reset        (reset),
      .counter      (counter_q),
      .write_data   (data),
      .cmp_write    (cmp_we[g]),
      .period_write (period_we[g]),
      .ctrl_write   (ctrl_we[g]),
      .status_clear (status_clear[g]),
      .cmp          (cmp_q[g]),
      .period       (period_q[g]),
      .ctrl         (ctrl_q[g]),
      .pending      (pending[g])
    );
    assign ie_vec[g] = ctrl_q[g].ie;
  end

  // Combinational read mux; reserved slots and CTRL upper bits read zero.
  always_comb begin
    read_value = '0;
    if (is_cnt)    read_value = counter_q;
    if (is_status) read_value = width'(pending);
    for (int i = 0; i < channels; i++) begin
      if (is_channel && ch_idx == width'(i)) begin
        case (int'(ch_reg))
          0:       read_value = cmp_q[i];
          1:       read_value = period_q[i];
          2:       read_value[MTIMER_CTRL_BITS-1:0] = ctrl_q[i];
          default: read_value = '0;
        endcase
      end
    end
  end

  assign rdata          = (MemRead && TimerAddress) ? read_value : {width{1'bz}};
  assign irq_pending    = pending;
  assign TimerInterrupt = |(pending & ie_vec);

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: a table of decode/reset reads followed
// by hand-written sequences for one-shot, periodic, masking, collision and
// reset behaviour.
module tb_multi_timer;
  import configurations::*;

  localparam logic [63:0] B       = MTIMER_BASE_ADDR;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] A_CNT   = B + 64'h00;
  localparam logic [63:0] A_STAT  = B + 64'h08;

  logic        clock;
  logic        reset;
  logic [63:0] address;
  logic [63:0] data;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] rdata;
  logic        TimerAddress;
  logic        TimerInterrupt;
  logic [3:0]  irq_pending;

  int total;
  int bad;

  multi_timer #(.width(64), .channels(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .data          (data),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .rdata         (rdata),
    .TimerAddress  (TimerAddress),
    .TimerInterrupt(TimerInterrupt),
    .irq_pending   (irq_pending)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic        rd;
    logic        exp_released;
    logic [63:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vectors[10];

  function automatic logic [63:0] cmp_a(input int ch);
    return B + 64'h20 + 64'h20 * 64'(ch);
  endfunction

  function automatic logic [63:0] per_a(input int ch);
    return B + 64'h28 + 64'h20 * 64'(ch);
  endfunction

  function automatic logic [63:0] ctrl_a(input int ch);
    return B + 64'h30 + 64'h20 * 64'(ch);
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
    end
  endtask

  // A two-state simulator resolves an undriven bus to zero, so either a
  // floating bus or all zeros is accepted as "released".
  task automatic check_released(input string name, input logic [63:0] actual);
    total++;
    if (!((actual === {64{1'bz}}) || (actual === 64'h0))) begin
      bad++;
      $display("[TB] FAIL %s: got %h, wanted high-Z", name, actual);
    end
  endtask

  task automatic apply_stimulus(input logic [63:0] addr, input logic rd,
                                output logic [63:0] value, output logic hit);
    address  = addr;
    MemRead  = rd;
    MemWrite = 1'b0;
    #1;
    value   = rdata;
    hit     = TimerAddress;
    MemRead = 1'b0;
  endtask

  task automatic bus_read(input logic [63:0] addr, output logic [63:0] value);
    logic hit;
    apply_stimulus(addr, 1'b1, value, hit);
  endtask

  task automatic bus_write(input logic [63:0] addr, input logic [63:0] value);
    @(negedge clock);
    address  = addr;
    data     = value;
    MemRead  = 1'b0;
    MemWrite = 1'b1;
    @(negedge clock);
    MemWrite = 1'b0;
  endtask

  task automatic wait_pending(input int idx, input int budget);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clock);
      if (irq_pending[idx] === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_pending%0d: got timeout, wanted pending", idx);
    end
  endtask

  task automatic wait_count(input logic [63:0] target, input int budget);
    logic [63:0] v;
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      bus_read(A_CNT, v);
      if (v == target) seen = 1'b1;
      else @(negedge clock);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_count: got timeout, wanted count %0d", target);
    end
  endtask

  initial begin
    logic [63:0] v;
    logic        hit;

    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    address  = '0;
    data     = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;

    vectors[0] = '{"cmp0_reset",    B + 64'h20, 1'b1, 1'b0, ONES,  1'b1};
    vectors[1] = '{"period0_reset", B + 64'h28, 1'b1, 1'b0, 64'h0, 1'b1};
    vectors[2] = '{"ctrl0_reset",   B + 64'h30, 1'b1, 1'b0, 64'h0, 1'b1};
    vectors[3] = '{"reserved0",     B + 64'h38, 1'b1, 1'b0, 64'h0, 1'b1};
    vectors[4] = '{"status_reset",  B + 64'h08, 1'b1, 1'b0, 64'h0, 1'b1};
    vectors[5] = '{"cmp3_reset",    B + 64'h80, 1'b1, 1'b0, ONES,  1'b1};
    vectors[6] = '{"unmapped_10",   B + 64'h10, 1'b1, 1'b1, 64'h0, 1'b0};
    vectors[7] = '{"past_last_ch",  B + 64'hA0, 1'b1, 1'b1, 64'h0, 1'b0};
    vectors[8] = '{"below_base",    B - 64'h08, 1'b1, 1'b1, 64'h0, 1'b0};
    vectors[9] = '{"hit_no_read",   B + 64'h20, 1'b0, 1'b1, 64'h0, 1'b1};

    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state and counting
    check_output("irq_after_reset", 64'(TimerInterrupt), 64'd0);
    bus_read(A_CNT, v); check_output("cnt_t0", v, 64'd0);
    @(negedge clock);
    bus_read(A_CNT, v); check_output("cnt_t1", v, 64'd1);
    @(negedge clock);
    bus_read(A_CNT, v); check_output("cnt_t2", v, 64'd2);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vectors[i].addr, vectors[i].rd, v, hit);
      if (vectors[i].exp_released) check_released({vectors[i].name, "_data"}, v);
      else check_output({vectors[i].name, "_data"}, v, vectors[i].exp_data);
      check_output({vectors[i].name, "_hit"}, 64'(hit), 64'(vectors[i].exp_hit));
    end

    // One-shot on channel 0
    bus_write(A_CNT, 64'd90);
    bus_write(cmp_a(0), 64'd100);
    bus_write(ctrl_a(0), 64'b101);
    wait_pending(0, 40);
    bus_read(A_CNT, v); check_output("oneshot_cnt", v, 64'd101);
    check_output("oneshot_irq", 64'(TimerInterrupt), 64'd1);
    bus_read(ctrl_a(0), v); check_output("oneshot_ctrl", v, 64'b100);
    bus_write(A_STAT, 64'd1);
    check_output("oneshot_ack_irq", 64'(TimerInterrupt), 64'd0);
    bus_write(A_CNT, 64'd98);
    repeat (5) @(negedge clock);
    check_output("oneshot_norefire", 64'(irq_pending), 64'd0);

    // Periodic on channel 1
    bus_write(A_CNT, 64'd40);
    bus_write(cmp_a(1), 64'd50);
    bus_write(per_a(1), 64'd20);
    bus_write(ctrl_a(1), 64'b111);
    wait_pending(1, 40);
    bus_read(A_CNT, v); check_output("periodic_cnt1", v, 64'd51);
    bus_write(A_STAT, 64'd2);
    wait_pending(1, 40);
    bus_read(A_CNT, v); check_output("periodic_cnt2", v, 64'd71);
    bus_write(A_STAT, 64'd2);
    wait_pending(1, 40);
    bus_read(A_CNT, v); check_output("periodic_cnt3", v, 64'd91);
    bus_read(cmp_a(1), v); check_output("periodic_cmp", v, 64'd110);
    bus_write(ctrl_a(1), 64'd0);
    bus_write(A_STAT, 64'd2);

    // Masking on channel 2
    bus_write(A_CNT, 64'd20);
    bus_write(cmp_a(2), 64'd30);
    bus_write(ctrl_a(2), 64'b001);
    wait_pending(2, 40);
    bus_read(A_CNT, v); check_output("mask_cnt", v, 64'd31);
    check_output("mask_pending", 64'(irq_pending), 64'b0100);
    check_output("mask_irq_low", 64'(TimerInterrupt), 64'd0);
    bus_write(ctrl_a(2), 64'b100);
    check_output("mask_irq_high", 64'(TimerInterrupt), 64'd1);
    bus_write(A_STAT, 64'd4);
    bus_write(ctrl_a(2), 64'd0);
    check_output("mask_cleared", 64'(irq_pending), 64'd0);

    // W1C in the match cycle: set wins
    bus_write(cmp_a(0), 64'd210);
    bus_write(ctrl_a(0), 64'b001);
    bus_write(A_CNT, 64'd200);
    wait_count(64'd209, 30);
    bus_write(A_STAT, 64'd1);
    check_output("w1c_collide_pend", 64'(irq_pending), 64'b0001);
    bus_read(ctrl_a(0), v); check_output("w1c_collide_ctrl", v, 64'd0);
    bus_write(A_STAT, 64'd1);
    check_output("w1c_after_ack", 64'(irq_pending), 64'd0);

    // CMP write during a periodic reload: CPU value kept
    bus_write(cmp_a(1), 64'd300);
    bus_write(per_a(1), 64'd20);
    bus_write(ctrl_a(1), 64'b011);
    bus_write(A_CNT, 64'd290);
    wait_count(64'd299, 30);
    bus_write(cmp_a(1), 64'd500);
    bus_read(cmp_a(1), v); check_output("reload_collide_cmp", v, 64'd500);
    check_output("reload_collide_pend", 64'(irq_pending), 64'b0010);
    bus_write(ctrl_a(1), 64'd0);
    bus_write(A_STAT, 64'd2);

    // CTRL write during a one-shot clear: CPU value kept
    bus_write(cmp_a(2), 64'd350);
    bus_write(ctrl_a(2), 64'b001);
    bus_write(A_CNT, 64'd340);
    wait_count(64'd349, 30);
    bus_write(ctrl_a(2), 64'b011);
    bus_read(ctrl_a(2), v); check_output("ctrl_collide_ctrl", v, 64'b011);
    check_output("ctrl_collide_pend", 64'(irq_pending), 64'b0100);
    bus_write(ctrl_a(2), 64'd0);
    bus_write(A_STAT, 64'd4);

    // CNT write in the match cycle: match still fires
    bus_write(cmp_a(0), 64'd400);
    bus_write(ctrl_a(0), 64'b001);
    bus_write(A_CNT, 64'd390);
    wait_count(64'd399, 30);
    bus_write(A_CNT, 64'd0);
    bus_read(A_CNT, v); check_output("cnt_collide_cnt", v, 64'd0);
    check_output("cnt_collide_pend", 64'(irq_pending), 64'b0001);

    // Asynchronous reset mid-run with an interrupt pending
    bus_write(ctrl_a(0), 64'b100);
    check_output("pre_reset_irq", 64'(TimerInterrupt), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_reset_irq", 64'(TimerInterrupt), 64'd0);
    check_output("async_reset_pend", 64'(irq_pending), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    bus_read(A_CNT, v); check_output("post_reset_cnt", v, 64'd0);
    bus_read(cmp_a(0), v); check_output("post_reset_cmp0", v, ONES);
    bus_read(ctrl_a(0), v); check_output("post_reset_ctrl0", v, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
